// File: rtl/bmp180_slave_if.sv
// rtl/bmp180_slave_if.sv - I2C line bundle between a bus master and the BMP180-style slave
interface bmp180_slave_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport slave (input scl_in, input sda_in, output sda_oe);
  modport master (output scl_in, output sda_in, input sda_oe);
endinterface

// File: rtl/bmp180_slave.sv
// rtl/bmp180_slave.sv - BMP180-style I2C register slave with host-loaded calibration and result registers
// Optional BMP180_SLAVE_SOFTRESET_EN: I2C write of 0xB6 to 0xE0 clears ctrl_meas and out registers.
module bmp180_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h77,
  parameter logic [7:0] CHIP_ID  = 8'h55
) (
  input  logic                 clk,
  input  logic                 reset,
  bmp180_slave_if.slave        i2c,
  input  logic                 reg_wr,
  input  logic [7:0]           reg_addr,
  input  logic [7:0]           reg_wdata,
  output logic [7:0]           ctrl_meas,
  output logic                 ctrl_strobe,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK} stateT;

  stateT       state, stateNext;
  logic        sclMeta, sclSync, sclPrev;
  logic        sdaMeta, sdaSync, sdaPrev;
  logic        sclRise, sclFall, startDet, stopDet;
  logic [3:0]  bitCnt;
  logic [7:0]  shiftReg;
  logic [7:0]  ptr;
  logic        sdaOe;
  logic        firstByte;
  logic        masterAck;
  logic        busyR;
  logic        addrMatch;
  logic        i2cRegWr;
  logic        softReset;
  logic [7:0]  rdCur, rdNext;

  logic [7:0]  cal [0:21];
  logic [7:0]  outReg [0:2];
  logic [7:0]  ctrlMeas;
  logic        ctrlWrote, ctrlStrobeR;
  logic        hostCal, hostOut;
  logic [4:0]  hostCalIdx;
  logic [1:0]  hostOutIdx;

  assign sclRise   = sclSync & ~sclPrev;
  assign sclFall   = ~sclSync & sclPrev;
  assign startDet  = sclSync & sclPrev & sdaPrev & ~sdaSync;
  assign stopDet   = sclSync & sclPrev & ~sdaPrev & sdaSync;
  assign addrMatch = (shiftReg[7:1] == DEV_ADDR);

  function automatic logic [7:0] regRead(input logic [7:0] a);
    logic [4:0] ci;
    ci = 5'(a - 8'hAA);
    regRead = 8'h00;
    if (a >= 8'hAA && a <= 8'hBF) regRead = cal[ci];
    else if (a == 8'hD0)          regRead = CHIP_ID;
    else if (a == 8'hF4)          regRead = ctrlMeas;
    else if (a == 8'hF6)          regRead = outReg[0];
    else if (a == 8'hF7)          regRead = outReg[1];
    else if (a == 8'hF8)          regRead = outReg[2];
  endfunction

  // Read data is fetched at load time, so host updates only affect bytes not yet shifted.
  assign rdCur  = regRead(ptr);
  assign rdNext = regRead(ptr + 8'd1);

  assign i2cRegWr = (state == WR_ACK) && sclFall && !firstByte;
`ifdef BMP180_SLAVE_SOFTRESET_EN
  assign softReset = i2cRegWr && (ptr == 8'hE0) && (shiftReg == 8'hB6);
`else
  assign softReset = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (startDet)     stateNext = ADDR;
    else if (stopDet) stateNext = IDLE;
    else begin
      case (state)
        ADDR:     if (sclFall && bitCnt == 4'd8) stateNext = addrMatch ? ADDR_ACK : IDLE;
        ADDR_ACK: if (sclFall) stateNext = shiftReg[0] ? RD_BYTE : WR_BYTE;
        WR_BYTE:  if (sclFall && bitCnt == 4'd8) stateNext = WR_ACK;
        WR_ACK:   if (sclFall) stateNext = WR_BYTE;
        RD_BYTE:  if (sclFall && bitCnt == 4'd8) stateNext = RD_ACK;
        RD_ACK:   if (sclFall) stateNext = masterAck ? RD_BYTE : IDLE;
        default:  stateNext = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclMeta   <= 1'b1;
      sclSync   <= 1'b1;
      sclPrev   <= 1'b1;
      sdaMeta   <= 1'b1;
      sdaSync   <= 1'b1;
      sdaPrev   <= 1'b1;
      bitCnt    <= 4'd0;
      shiftReg  <= 8'h00;
      ptr       <= 8'h00;
      sdaOe     <= 1'b0;
      firstByte <= 1'b0;
      masterAck <= 1'b0;
      busyR     <= 1'b0;
    end else begin
      sclMeta <= i2c.scl_in;
      sclSync <= sclMeta;
      sclPrev <= sclSync;
      sdaMeta <= i2c.sda_in;
      sdaSync <= sdaMeta;
      sdaPrev <= sdaSync;
      if (startDet) begin
        busyR  <= 1'b1;
        bitCnt <= 4'd0;
        sdaOe  <= 1'b0;
      end else if (stopDet) begin
        busyR <= 1'b0;
        sdaOe <= 1'b0;
      end else begin
        case (state)
          ADDR, WR_BYTE: begin
            if (sclRise) begin
              shiftReg <= {shiftReg[6:0], sdaSync};
              bitCnt   <= bitCnt + 4'd1;
            end
            // Data bytes are always ACKed; address bytes only on a match.
            if (sclFall && bitCnt == 4'd8) begin
              bitCnt <= 4'd0;
              sdaOe  <= (state == WR_BYTE) || addrMatch;
            end
          end
          ADDR_ACK: if (sclFall) begin
            bitCnt    <= 4'd0;
            firstByte <= 1'b1;
            if (shiftReg[0]) begin
              shiftReg <= rdCur;
              sdaOe    <= ~rdCur[7];
            end else begin
              sdaOe <= 1'b0;
            end
          end
          WR_ACK: if (sclFall) begin
            sdaOe     <= 1'b0;
            firstByte <= 1'b0;
            if (firstByte) ptr <= shiftReg;
            else           ptr <= ptr + 8'd1;
          end
          RD_BYTE: begin
            if (sclRise) bitCnt <= bitCnt + 4'd1;
            if (sclFall) begin
              if (bitCnt == 4'd8) begin
                sdaOe  <= 1'b0;
                bitCnt <= 4'd0;
              end else begin
                shiftReg <= {shiftReg[6:0], 1'b0};
                sdaOe    <= ~shiftReg[6];
              end
            end
          end
          RD_ACK: begin
            if (sclRise) masterAck <= ~sdaSync;
            if (sclFall) begin
              if (masterAck) begin
                ptr      <= ptr + 8'd1;
                shiftReg <= rdNext;
                sdaOe    <= ~rdNext[7];
              end else begin
                sdaOe <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign hostCal    = reg_wr && (reg_addr >= 8'hAA) && (reg_addr <= 8'hBF);
  assign hostOut    = reg_wr && (reg_addr >= 8'hF6) && (reg_addr <= 8'hF8);
  assign hostCalIdx = 5'(reg_addr - 8'hAA);
  assign hostOutIdx = 2'(reg_addr - 8'hF6);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 22; i++) cal[i] <= 8'h00;
      for (int i = 0; i < 3; i++) outReg[i] <= 8'h00;
      ctrlMeas    <= 8'h00;
      ctrlWrote   <= 1'b0;
      ctrlStrobeR <= 1'b0;
    end else begin
      ctrlWrote   <= i2cRegWr && (ptr == 8'hF4);
      ctrlStrobeR <= ctrlWrote;
      if (hostCal) cal[hostCalIdx] <= reg_wdata;
      if (softReset) begin
        for (int i = 0; i < 3; i++) outReg[i] <= 8'h00;
      end else if (hostOut) begin
        outReg[hostOutIdx] <= reg_wdata;
      end
      if (i2cRegWr && ptr == 8'hF4) ctrlMeas <= shiftReg;
      else if (softReset)           ctrlMeas <= 8'h00;
    end
  end

  assign i2c.sda_oe  = sdaOe;
  assign ctrl_meas   = ctrlMeas;
  assign ctrl_strobe = ctrlStrobeR;
  assign busy        = busyR;

endmodule

// File: tb/tb_bmp180_slave.sv
// tb/tb_bmp180_slave.sv - scoreboard bench driving a bit-banged I2C master against bmp180_slave
module tb_bmp180_slave;
  localparam int Q = 10;
`ifdef BMP180_SLAVE_SOFTRESET_EN
  localparam bit SOFTRST = 1'b1;
`else
  localparam bit SOFTRST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       sclDrv, sdaDrv, sdaLine;
  logic       regWr;
  logic [7:0] regAddr, regWdata;
  logic [7:0] ctrlMeas;
  logic       ctrlStrobe, busy;
  int         total = 0;
  int         bad = 0;

  string      expNameQ[$];
  logic [7:0] expValQ[$];
  logic [7:0] obsQ[$];
  logic [7:0] ctrlExpQ[$];

  always #5 clk = ~clk;

  bmp180_slave_if bus();
  assign sdaLine    = sdaDrv & ~bus.sda_oe;
  assign bus.scl_in = sclDrv;
  assign bus.sda_in = sdaLine;

  bmp180_slave dut (
    .clk(clk), .reset(reset), .i2c(bus),
    .reg_wr(regWr), .reg_addr(regAddr), .reg_wdata(regWdata),
    .ctrl_meas(ctrlMeas), .ctrl_strobe(ctrlStrobe), .busy(busy)
  );

  task automatic pushExp(input string n, input logic [7:0] v);
    expNameQ.push_back(n);
    expValQ.push_back(v);
  endtask

  task automatic observe(input logic [7:0] v);
    obsQ.push_back(v);
  endtask

  task automatic check(input string n, input logic [7:0] e, input logic [7:0] a);
    pushExp(n, e);
    observe(a);
  endtask

  task automatic waitQ();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bitCycle(input logic drv, output logic smp);
    sdaDrv = drv;
    waitQ();
    sclDrv = 1'b1;
    waitQ();
    smp = sdaLine;
    waitQ();
    sclDrv = 1'b0;
    waitQ();
  endtask

  task automatic i2cStart();
    sdaDrv = 1'b1;
    waitQ();
    sclDrv = 1'b1;
    waitQ();
    sdaDrv = 1'b0;
    waitQ();
    sclDrv = 1'b0;
    waitQ();
  endtask

  task automatic i2cStop();
    sdaDrv = 1'b0;
    waitQ();
    sclDrv = 1'b1;
    waitQ();
    sdaDrv = 1'b1;
    waitQ();
    waitQ();
  endtask

  task automatic writeByte(input logic [7:0] b, input logic ackExp);
    logic s;
    pushExp($sformatf("ack_%02h", b), {7'd0, ackExp});
    for (int i = 7; i >= 0; i--) bitCycle(b[i], s);
    bitCycle(1'b1, s);
    observe({7'd0, ~s});
  endtask

  task automatic readByte(input logic [7:0] e, input logic ack);
    logic [7:0] v;
    logic       s;
    pushExp($sformatf("rd_%02h", e), e);
    for (int i = 7; i >= 0; i--) begin
      bitCycle(1'b1, s);
      v[i] = s;
    end
    bitCycle(~ack, s);
    observe(v);
  endtask

  task automatic setPtrRead(input logic [7:0] a);
    i2cStart();
    writeByte(8'hEE, 1'b1);
    writeByte(a, 1'b1);
    i2cStart();
    writeByte(8'hEF, 1'b1);
  endtask

  task automatic hostWrite(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    regWr = 1'b1;
    regAddr = a;
    regWdata = d;
    @(negedge clk);
    regWr = 1'b0;
  endtask

  // Monitor: compares every observation and ctrl_strobe pulse against queued expectations.
  initial begin
    logic [7:0] a, e;
    string n;
    forever begin
      @(negedge clk);
      if (ctrlStrobe) begin
        total++;
        if (ctrlExpQ.size() == 0) begin
          bad++;
          $display("FAIL ctrl_strobe unexpected pulse ctrl_meas=%02h", ctrlMeas);
        end else begin
          e = ctrlExpQ.pop_front();
          if (ctrlMeas !== e) begin
            bad++;
            $display("FAIL ctrl_strobe actual=%02h required=%02h", ctrlMeas, e);
          end
        end
      end
      while (obsQ.size() > 0) begin
        a = obsQ.pop_front();
        total++;
        if (expValQ.size() == 0) begin
          bad++;
          $display("FAIL unexpected observation actual=%02h", a);
        end else begin
          n = expNameQ.pop_front();
          e = expValQ.pop_front();
          if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%02h required=%02h", n, a, e);
          end
        end
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic s;
    reset = 1'b1;
    sclDrv = 1'b1;
    sdaDrv = 1'b1;
    regWr = 1'b0;
    regAddr = 8'h00;
    regWdata = 8'h00;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_sda_oe", 8'h00, {7'd0, bus.sda_oe});
    check("rst_busy", 8'h00, {7'd0, busy});
    check("rst_strobe", 8'h00, {7'd0, ctrlStrobe});
    check("rst_ctrl", 8'h00, ctrlMeas);

    // Chip id via write-pointer, repeated start, single read with NACK
    i2cStart();
    check("busy_start", 8'h01, {7'd0, busy});
    writeByte(8'hEE, 1'b1);
    writeByte(8'hD0, 1'b1);
    i2cStart();
    writeByte(8'hEF, 1'b1);
    readByte(8'h55, 1'b0);
    i2cStop();
    check("stop_sda_oe", 8'h00, {7'd0, bus.sda_oe});
    check("stop_busy", 8'h00, {7'd0, busy});

    // Calibration burst read across the whole 22-byte block
    for (int i = 0; i < 22; i++) hostWrite(8'hAA + 8'(i), 8'h10 + 8'(i));
    hostWrite(8'hF4, 8'h99);
    check("host_f4_ignored", 8'h00, ctrlMeas);
    setPtrRead(8'hAA);
    for (int i = 0; i < 22; i++) readByte(8'h10 + 8'(i), i != 21);
    i2cStop();

    // ctrl_meas write then read back
    ctrlExpQ.push_back(8'h2E);
    i2cStart();
    writeByte(8'hEE, 1'b1);
    writeByte(8'hF4, 1'b1);
    writeByte(8'h2E, 1'b1);
    i2cStop();
    check("ctrl_meas_2e", 8'h2E, ctrlMeas);
    setPtrRead(8'hF4);
    readByte(8'h2E, 1'b0);
    i2cStop();

    // Wrong address: no ACK anywhere, busy until STOP, no register change
    i2cStart();
    writeByte(8'hEC, 1'b0);
    check("busy_nack", 8'h01, {7'd0, busy});
    writeByte(8'hF4, 1'b0);
    writeByte(8'h11, 1'b0);
    i2cStop();
    check("busy_after_nack_stop", 8'h00, {7'd0, busy});
    check("ctrl_after_nack", 8'h2E, ctrlMeas);

    // Out registers then an unmapped address reading zero
    hostWrite(8'hF6, 8'hA1);
    hostWrite(8'hF7, 8'hB2);
    hostWrite(8'hF8, 8'hC3);
    setPtrRead(8'hF6);
    readByte(8'hA1, 1'b1);
    readByte(8'hB2, 1'b1);
    readByte(8'hC3, 1'b1);
    readByte(8'h00, 1'b0);
    i2cStop();

    // Reset in the 4th bit of a read of 0x2E (that bit is 0, so SDA is pulled)
    setPtrRead(8'hF4);
    for (int i = 0; i < 3; i++) bitCycle(1'b1, s);
    sdaDrv = 1'b1;
    waitQ();
    check("rd_bit4_driven", 8'h01, {7'd0, bus.sda_oe});
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_sda_oe", 8'h00, {7'd0, bus.sda_oe});
    @(negedge clk);
    reset = 1'b0;
    i2cStop();
    check("rst_mid_busy", 8'h00, {7'd0, busy});
    check("rst_mid_ctrl", 8'h00, ctrlMeas);
    setPtrRead(8'hD0);
    readByte(8'h55, 1'b0);
    i2cStop();

    // Soft reset command
    hostWrite(8'hAA, 8'h10);
    hostWrite(8'hF6, 8'h77);
    ctrlExpQ.push_back(8'h34);
    i2cStart();
    writeByte(8'hEE, 1'b1);
    writeByte(8'hF4, 1'b1);
    writeByte(8'h34, 1'b1);
    i2cStop();
    check("ctrl_meas_34", 8'h34, ctrlMeas);
    i2cStart();
    writeByte(8'hEE, 1'b1);
    writeByte(8'hE0, 1'b1);
    writeByte(8'hB6, 1'b1);
    i2cStop();
    check("ctrl_after_e0", SOFTRST ? 8'h00 : 8'h34, ctrlMeas);
    setPtrRead(8'hAA);
    readByte(8'h10, 1'b0);
    i2cStop();
    setPtrRead(8'hF6);
    readByte(SOFTRST ? 8'h00 : 8'h77, 1'b0);
    i2cStop();

    repeat (20) @(negedge clk);
    while (expValQ.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s missing observation required=%02h", expNameQ.pop_front(), expValQ.pop_front());
    end
    while (ctrlExpQ.size() > 0) begin
      total++;
      bad++;
      $display("FAIL ctrl_strobe missing pulse required=%02h", ctrlExpQ.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bmp180_slave.md
BMP180_SLAVE -- requirements
Module: bmp180_slave

Interface
REQ-001 Parameter DEV_ADDR, default 7'h77, 7-bit I2C device address answered.
REQ-002 Parameter CHIP_ID, default 8'h55, value returned from register 0xD0.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 scl_in  input  1  I2C SCL line level, asynchronous.
REQ-006 sda_in  input  1  I2C SDA line level, asynchronous.
REQ-007 sda_oe  output  1  open-drain SDA pull-low enable; 1 = drive line low.
REQ-008 reg_wr  input  1  host write strobe into the slave register file, one cycle.
REQ-009 reg_addr  input  8  host write register address.
REQ-010 reg_wdata  input  8  host write data.
REQ-011 ctrl_meas  output  8  last value written by the I2C master to register 0xF4.
REQ-012 ctrl_strobe  output  1  one-cycle pulse when the master writes 0xF4.
REQ-013 busy  output  1  high from detected START to detected STOP.

Function
REQ-014 scl_in and sda_in each pass through 2-FF synchronizers; edges and START/STOP are detected on the synchronized values (3-cycle detect latency).
REQ-015 START = SDA falls while SCL high; STOP = SDA rises while SCL high; repeated START is accepted in any state.
REQ-016 States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
REQ-017 START -> ADDR, bit counter cleared; STOP -> IDLE from any state, sda_oe released the same cycle.
REQ-018 Bits sampled MSB first on SCL rising edge; sda_oe changes only on the cycle after an SCL falling-edge detect.
REQ-019 ADDR: after 8 bits, address match -> ADDR_ACK (sda_oe=1 for the 9th clock); mismatch -> IDLE, no ACK.
REQ-020 ADDR_ACK: R/W=0 -> WR_BYTE; R/W=1 -> RD_BYTE, shift register loaded from current register pointer.
REQ-021 First byte of a write transaction loads the register pointer; subsequent bytes write register[pointer], pointer increments; every byte ACKed.
REQ-022 RD_BYTE drives register[pointer] MSB first (sda_oe = ~bit); in RD_ACK master ACK -> pointer increments, next byte loaded; NACK -> IDLE awaiting STOP.
REQ-023 Pointer is 8 bits and wraps 0xFF -> 0x00.
REQ-024 Map: 0xAA..0xBF calibration (22 bytes, host-written, read-only to I2C); 0xD0 CHIP_ID; 0xF4 ctrl_meas (R/W); 0xF6..0xF8 out_msb/out_lsb/out_xlsb (host-written, read-only to I2C); all other addresses read 0x00, I2C writes ignored but ACKed.
REQ-025 Host reg_wr to 0xAA..0xBF or 0xF6..0xF8 updates storage; other host addresses ignored; if host and I2C write collide on the same cycle, the I2C write to 0xF4 wins and host writes never touch 0xF4.
REQ-026 Host writes during an in-progress I2C read affect only bytes not yet loaded into the shift register.
REQ-027 ctrl_strobe pulses the cycle after ctrl_meas updates.

Reset
REQ-028 On reset: state IDLE, sda_oe=0, busy=0, ctrl_strobe=0, ctrl_meas=0x00, pointer=0x00, calibration and out registers 0x00, synchronizers set to 1.
REQ-029 Reset mid-transaction releases SDA the next cycle; the bus is ignored until the next START.

Configuration
REQ-030 Macro BMP180_SLAVE_SOFTRESET_EN defined: I2C write of 0xB6 to 0xE0 clears ctrl_meas and out registers to 0x00 at the end of that byte's ACK; calibration retained; the write is ACKed.
REQ-031 Macro undefined: writes to 0xE0 are ACKed and ignored.

Verification
REQ-032 Write 0xEE,0xD0, Sr, 0xEF, read 1 with NACK -> slave ACKs 3 bytes, returns 0x55, sda_oe=0 after STOP.
REQ-033 Host loads 0xAA..0xBF with 0x10..0x25; master reads 22 bytes from 0xAA -> 0x10..0x25 in order, last NACKed.
REQ-034 Master writes 0xEE,0xF4,0x2E -> ctrl_meas=0x2E, one ctrl_strobe pulse; read of 0xF4 returns 0x2E.
REQ-035 Address byte 0xEC -> no ACK, busy high until STOP, no register change.
REQ-036 Assert reset during the 4th bit of a read data byte -> sda_oe=0 next cycle; next transaction reads 0x55 from 0xD0 correctly.
REQ-037 With BMP180_SLAVE_SOFTRESET_EN: ctrl_meas=0x34, write 0xB6 to 0xE0 -> ctrl_meas=0x00, calibration unchanged; without macro -> ctrl_meas stays 0x34.
